// File: rtl/des_key_schedule_if.sv
// Start/done handshake and round-key bus between a key schedule and its consumer.
// The master drives the request; the slave (key schedule) returns status and keys.
interface des_key_schedule_if;
  logic         start;
  logic [1:64]  key;
  logic         decrypt;
  logic         busy;
  logic         done;
  logic [1:768] round_keys;

  modport master (output start, key, decrypt, input busy, done, round_keys);
  modport slave  (input start, key, decrypt, output busy, done, round_keys);
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on start, then KEYS_PER_CYCLE C/D rotation and
// PC-2 stages per clock, filling sixteen 48-bit slots in encryption or reversed order.
module des_key_schedule #(
  parameter int KEYS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  des_key_schedule_if.slave  bus
);

  typedef enum logic {IDLE, ROUND} state_t;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  state_t       state_reg, state_next;
  logic [1:28]  c_reg, c_next;
  logic [1:28]  d_reg, d_next;
  logic [4:0]   counter_reg, counter_next;
  logic         decrypt_reg, decrypt_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic [1:768] round_keys_reg, round_keys_next;

  logic [1:56]  pc1_key;
  logic [7:0]   unused_parity;

  logic [1:28]  c_tmp, d_tmp;
  logic [4:0]   round_num;
  logic [4:0]   slot;
  logic         single_shift;
  logic [1:48]  round_key;
  logic [9:0]   slot_base;

  // PC-1 is pure wiring; the parity bits (every eighth key bit) never reach it.
  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_key[gi+1] = bus.key[PC1[gi]];
    end
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign unused_parity[gi] = bus.key[8*gi+8];
    end
  endgenerate

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] k;
    for (int i = 0; i < 48; i++) begin
      k[i+1] = cd[PC2[i]];
    end
    return k;
  endfunction

  always_comb begin
    state_next      = state_reg;
    c_next          = c_reg;
    d_next          = d_reg;
    counter_next    = counter_reg;
    decrypt_next    = decrypt_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    round_keys_next = round_keys_reg;
    c_tmp           = c_reg;
    d_tmp           = d_reg;
    round_num       = 5'd0;
    slot            = 5'd0;
    single_shift    = 1'b0;
    round_key       = '0;
    slot_base       = 10'd0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          c_next       = pc1_key[1:28];
          d_next       = pc1_key[29:56];
          decrypt_next = bus.decrypt;
          counter_next = 5'd0;
          busy_next    = 1'b1;
          state_next   = ROUND;
        end
      end
      ROUND: begin
        for (int s = 0; s < KEYS_PER_CYCLE; s++) begin
          round_num    = counter_reg + 5'(s + 1);
          single_shift = (round_num == 5'd1) || (round_num == 5'd2) ||
                         (round_num == 5'd9) || (round_num == 5'd16);
          c_tmp = single_shift ? {c_tmp[2:28], c_tmp[1]} : {c_tmp[3:28], c_tmp[1:2]};
          d_tmp = single_shift ? {d_tmp[2:28], d_tmp[1]} : {d_tmp[3:28], d_tmp[1:2]};
          round_key = pc2({c_tmp, d_tmp});
          slot      = decrypt_reg ? (5'd17 - round_num) : round_num;
          slot_base = 10'd48 * {5'd0, slot - 5'd1} + 10'd1;
          round_keys_next[slot_base +: 48] = round_key;
        end
        c_next       = c_tmp;
        d_next       = d_tmp;
        counter_next = counter_reg + 5'(KEYS_PER_CYCLE);
        if (counter_next == 5'd16) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      c_reg          <= '0;
      d_reg          <= '0;
      counter_reg    <= '0;
      decrypt_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      round_keys_reg <= '0;
    end else begin
      state_reg      <= state_next;
      c_reg          <= c_next;
      d_reg          <= d_next;
      counter_reg    <= counter_next;
      decrypt_reg    <= decrypt_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      round_keys_reg <= round_keys_next;
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.round_keys = round_keys_reg;

endmodule
